// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the load/store control sequencer.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // Default opcode values. The instruction opcode is IRregister[31:27].
  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // Sequencer states. T1_WAIT is the stretched part of the fetch read, so
  // that PCin/IncPC appear only in the final cycle (T1).
  typedef enum logic [3:0] {
    RESET_ST,
    T0,
    T1_WAIT,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    T7,
    PAUSE,
    HALT
  } state_t;

  localparam logic [3:0] T_IDX_HALT = 4'd15;

  // Debug step index shown on the T output. RESET_ST and PAUSE report 0.
  function automatic logic [3:0] t_index(input state_t s);
    logic [3:0] idx;
    idx = 4'd0;
    case (s)
      T1_WAIT, T1: idx = 4'd1;
      T2:          idx = 4'd2;
      T3:          idx = 4'd3;
      T4:          idx = 4'd4;
      T5:          idx = 4'd5;
      T6:          idx = 4'd6;
      T7:          idx = 4'd7;
      HALT:        idx = T_IDX_HALT;
      default:     idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that stretches a memory-access step by a loaded number of cycles.
// Latency: load takes effect on the next edge; done is a decode of the count.
// Backpressure: none; dec is ignored once the count has reached zero.
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/ldst_control_unit.sv
// Moore sequencer producing fetch and ld/ldi/st/halt control strobes from IRregister.
// Latency: strobes are a decode of the registered state; opcode captured on the T2->T3 edge.
// Backpressure: Stop pauses only at an instruction boundary; MEM_WAIT stretches T1, T6 (ld), T7 (st).
module ldst_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] OP_LD    = OPC_LD,
  parameter logic [4:0] OP_LDI   = OPC_LDI,
  parameter logic [4:0] OP_ST    = OPC_ST,
  parameter logic [4:0] OP_HALT  = OPC_HALT
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IRregister,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        PCin,
  output logic        IncPC,
  output logic        MDRout,
  output logic        IRin,
  output logic        Grb,
  output logic        BAout,
  output logic        Yin,
  output logic        Cout,
  output logic        ADD,
  output logic        Zin,
  output logic        ZLOout,
  output logic        Gra,
  output logic        Rin,
  output logic        Rout,
  output logic        write,
  output logic [3:0]  T
);

  // Full stretch for T6/T7, and one less for T1_WAIT because the final
  // read cycle is T1 itself.
  localparam logic [3:0] WAIT_LEN = 4'(MEM_WAIT);
  localparam logic [3:0] WAIT_T1  = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] opcode_q;
  logic [4:0] opcode_d;
  logic       cnt_load;
  logic [3:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_done;
  logic       at_boundary;
  logic       is_ld;
  logic       is_ldi;
  logic       is_st;

  // Only the opcode field of the instruction matters to the sequencer.
  logic       unused_ir;
  assign unused_ir = ^IRregister[26:0];

  assign is_ld  = (opcode_q == OP_LD);
  assign is_ldi = (opcode_q == OP_LDI);
  assign is_st  = (opcode_q == OP_ST);

  mem_wait_counter u_wait (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Next-state logic; every path that ends an instruction goes through the
  // boundary check so Stop is only honoured there.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    cnt_load    = 1'b0;
    cnt_val     = WAIT_LEN;
    cnt_dec     = 1'b0;
    at_boundary = 1'b0;
    case (state_q)
      RESET_ST: state_d = T0;
      T0: begin
        if (WAIT_LEN == 4'd0) begin
          state_d = T1;
        end else begin
          state_d  = T1_WAIT;
          cnt_load = 1'b1;
          cnt_val  = WAIT_T1;
        end
      end
      T1_WAIT: begin
        if (cnt_done) state_d = T1;
        else          cnt_dec = 1'b1;
      end
      T1: state_d = T2;
      T2: begin
        state_d  = T3;
        opcode_d = IRregister[31:27];
      end
      T3: begin
        if (is_ld || is_ldi || is_st)  state_d = T4;
        else if (opcode_q == OP_HALT)  state_d = HALT;
        else                           at_boundary = 1'b1;
      end
      T4: state_d = T5;
      T5: begin
        if (is_ldi) begin
          at_boundary = 1'b1;
        end else begin
          state_d = T6;
          if (is_ld) cnt_load = 1'b1;
        end
      end
      T6: begin
        if (is_st) begin
          state_d  = T7;
          cnt_load = 1'b1;
        end else if (cnt_done) begin
          state_d = T7;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      T7: begin
        if (is_st && !cnt_done) cnt_dec = 1'b1;
        else                    at_boundary = 1'b1;
      end
      PAUSE:   state_d = Stop ? PAUSE : T0;
      HALT:    state_d = HALT;
      default: state_d = RESET_ST;
    endcase
    if (at_boundary) begin
      state_d = Stop ? PAUSE : T0;
    end
  end

  // State and captured-opcode registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= RESET_ST;
      opcode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Strobe decode from the registered state; RESET_ST, PAUSE and HALT drive nothing.
  always_comb begin
    Run    = 1'b0;
    PCout  = 1'b0;
    MARin  = 1'b0;
    Read   = 1'b0;
    MDRin  = 1'b0;
    PCin   = 1'b0;
    IncPC  = 1'b0;
    MDRout = 1'b0;
    IRin   = 1'b0;
    Grb    = 1'b0;
    BAout  = 1'b0;
    Yin    = 1'b0;
    Cout   = 1'b0;
    ADD    = 1'b0;
    Zin    = 1'b0;
    ZLOout = 1'b0;
    Gra    = 1'b0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    write  = 1'b0;
    T      = t_index(state_q);
    case (state_q)
      T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1;
      end
      T1_WAIT: begin
        Run = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      T1: begin
        Run = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1;
      end
      T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        Run = 1'b1;
        if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end
      end
      T4: begin
        Run = 1'b1; Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
      end
      T5: begin
        Run = 1'b1; ZLOout = 1'b1;
        if (is_ldi) begin
          Gra = 1'b1; Rin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      T6: begin
        Run = 1'b1; MDRin = 1'b1;
        if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; write = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      T7: begin
        Run = 1'b1;
        if (is_st) begin
          write = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      default: begin
        Run = 1'b0;
      end
    endcase
  end

endmodule
